// File: rtl/cpu_pkg.sv
// Shared types and constants for the five-stage MIPS core hazard logic.
// Holds forward-select codes, the Tuse/Tnew width and the per-stage records.
package cpu_pkg;

    localparam int unsigned TW = 2;

    localparam logic [1:0] FWD_PIPE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    typedef struct packed {
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    dst;
        logic [TW-1:0] tnew;
        logic          md_start;
        logic          md_div;
    } e_rec_t;

    typedef struct packed {
        logic [4:0]    rt;
        logic [4:0]    dst;
        logic [TW-1:0] tnew;
    } m_rec_t;

    typedef struct packed {
        logic [4:0] dst;
    } w_rec_t;

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority matcher: picks the nearest enabled stage whose destination equals src.
// The nearest match decides; if its result is not ready yet the select stays at pipe.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [4:0]    src_i,
    input  logic          e_en_i,
    input  logic [4:0]    e_dst_i,
    input  logic [TW-1:0] e_tnew_i,
    input  logic          m_en_i,
    input  logic [4:0]    m_dst_i,
    input  logic [TW-1:0] m_tnew_i,
    input  logic          w_en_i,
    input  logic [4:0]    w_dst_i,
    output logic [1:0]    sel_o
);

    always_comb begin
        sel_o = FWD_PIPE;
        if (src_i != 5'd0) begin
            if (e_en_i && (src_i == e_dst_i)) begin
                sel_o = (e_tnew_i == '0) ? FWD_E : FWD_PIPE;
            end else if (m_en_i && (src_i == m_dst_i)) begin
                sel_o = (m_tnew_i == '0) ? FWD_M : FWD_PIPE;
            end else if (w_en_i && (src_i == w_dst_i)) begin
                sel_o = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: stall/flush and forwarding selects from E/M/W records.
// Define HAZARD_MDU_EN to build multiply/divide occupancy tracking and HI/LO interlock.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       use_rs_d,
    input  logic       use_rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] dst_d,
    input  logic [1:0] tnew_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       stall,
    output logic       flush_e,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic [1:0] fwd_rt_m,
    output logic       md_busy
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    e_rec_t e_q, e_d;
    m_rec_t m_q, m_d;
    w_rec_t w_q, w_d;

    logic       haz_rs, haz_rt, haz_md;
    logic [1:0] rt_m_sel;

    always_comb begin
        haz_rs = use_rs_d && (rs_d != 5'd0) &&
                 (((rs_d == e_q.dst) && (e_q.tnew > tuse_rs_d)) ||
                  ((rs_d == m_q.dst) && (m_q.tnew > tuse_rs_d)));
        haz_rt = use_rt_d && (rt_d != 5'd0) &&
                 (((rt_d == e_q.dst) && (e_q.tnew > tuse_rt_d)) ||
                  ((rt_d == m_q.dst) && (m_q.tnew > tuse_rt_d)));
        stall   = haz_rs | haz_rt | haz_md;
        flush_e = stall;
    end

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs   = rs_d;
            e_d.rt   = rt_d;
            e_d.dst  = dst_d;
            e_d.tnew = tnew_d;
`ifdef HAZARD_MDU_EN
            e_d.md_start = md_start_d;
            e_d.md_div   = md_div_d;
`endif
        end
        m_d.rt   = e_q.rt;
        m_d.dst  = e_q.dst;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d.dst  = m_q.dst;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_MDU_EN
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (e_q.md_start) begin
            cnt_d = e_q.md_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
        md_busy = e_q.md_start | (cnt_q != '0);
        haz_md  = (md_start_d | md_use_d) & md_busy;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_md;

    always_comb begin
        md_busy   = 1'b0;
        haz_md    = 1'b0;
        unused_md = ^{md_start_d, md_div_d, md_use_d, e_q.md_start, e_q.md_div};
    end
`endif

    fwd_sel u_fwd_rs_d (
        .src_i   (rs_d),
        .e_en_i  (1'b1),
        .e_dst_i (e_q.dst),
        .e_tnew_i(e_q.tnew),
        .m_en_i  (1'b1),
        .m_dst_i (m_q.dst),
        .m_tnew_i(m_q.tnew),
        .w_en_i  (1'b1),
        .w_dst_i (w_q.dst),
        .sel_o   (fwd_rs_d)
    );

    fwd_sel u_fwd_rt_d (
        .src_i   (rt_d),
        .e_en_i  (1'b1),
        .e_dst_i (e_q.dst),
        .e_tnew_i(e_q.tnew),
        .m_en_i  (1'b1),
        .m_dst_i (m_q.dst),
        .m_tnew_i(m_q.tnew),
        .w_en_i  (1'b1),
        .w_dst_i (w_q.dst),
        .sel_o   (fwd_rt_d)
    );

    fwd_sel u_fwd_rs_e (
        .src_i   (e_q.rs),
        .e_en_i  (1'b0),
        .e_dst_i (5'd0),
        .e_tnew_i('0),
        .m_en_i  (1'b1),
        .m_dst_i (m_q.dst),
        .m_tnew_i(m_q.tnew),
        .w_en_i  (1'b1),
        .w_dst_i (w_q.dst),
        .sel_o   (fwd_rs_e)
    );

    fwd_sel u_fwd_rt_e (
        .src_i   (e_q.rt),
        .e_en_i  (1'b0),
        .e_dst_i (5'd0),
        .e_tnew_i('0),
        .m_en_i  (1'b1),
        .m_dst_i (m_q.dst),
        .m_tnew_i(m_q.tnew),
        .w_en_i  (1'b1),
        .w_dst_i (w_q.dst),
        .sel_o   (fwd_rt_e)
    );

    fwd_sel u_fwd_rt_m (
        .src_i   (m_q.rt),
        .e_en_i  (1'b0),
        .e_dst_i (5'd0),
        .e_tnew_i('0),
        .m_en_i  (1'b0),
        .m_dst_i (5'd0),
        .m_tnew_i('0),
        .w_en_i  (1'b1),
        .w_dst_i (w_q.dst),
        .sel_o   (rt_m_sel)
    );

    // Store-data mux is two-input: W data sits on select 2
    always_comb begin
        fwd_rt_m = (rt_m_sel == FWD_W) ? FWD_M : FWD_PIPE;
    end

endmodule
